// File: rtl/dac_chain_pkg.sv
// Shared widths, constants and sample/carrier types for the DAC transmit chain.
package dac_chain_pkg;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned CARRIER_W = 8;
  localparam int unsigned DAC_W     = 14;
  localparam int unsigned PROD_W    = SAMPLE_W + CARRIER_W;
  localparam int unsigned SUM_W     = PROD_W + 1;
  localparam int unsigned OUT_LSB   = 7;
  localparam int unsigned OUT_MSB   = OUT_LSB + DAC_W - 1;
  localparam int unsigned RATIO_W   = 16;

  localparam logic [DAC_W-1:0] DAC_MID = 14'h2000;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] q;
    logic signed [SAMPLE_W-1:0] i;
  } iq_t;

  typedef struct packed {
    logic signed [CARRIER_W-1:0] sin_v;
    logic signed [CARRIER_W-1:0] cos_v;
  } carrier_t;

  function automatic logic [RATIO_W-1:0] eff_ratio(input logic [RATIO_W-1:0] r);
    return (r == '0) ? RATIO_W'(1) : r;
  endfunction
endpackage

// File: rtl/dac_chain_if.sv
// AXI-Stream style baseband sample channel feeding the DAC chain.
interface dac_chain_if;
  import dac_chain_pkg::*;

  logic [2*SAMPLE_W-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic [3:0]            tkeep;
  logic                  tlast;

  modport master (output tdata, tvalid, tkeep, tlast, input tready);
  modport slave  (input tdata, tvalid, tkeep, tlast, output tready);
endinterface

// File: rtl/dac_chain_mixer.sv
// Three-stage I/Q upconversion mixer with saturation to an offset-binary DAC code.
module dac_chain_mixer
  import dac_chain_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  iq_t              hold_i,
  input  carrier_t         carrier_i,
  output logic [DAC_W-1:0] dac_o
);
  logic signed [PROD_W-1:0] p_i_q, p_i_d, p_q_q, p_q_d;
  logic signed [SUM_W-1:0]  diff_q, diff_d;
  logic signed [DAC_W-1:0]  sat;
  logic [SUM_W-1-OUT_MSB:0] top;
  logic [DAC_W-1:0]         dac_q, dac_d;

  always_comb begin
    p_i_d  = PROD_W'(hold_i.i) * PROD_W'(carrier_i.cos_v);
    p_q_d  = PROD_W'(hold_i.q) * PROD_W'(carrier_i.sin_v);
    diff_d = SUM_W'(p_i_q) - SUM_W'(p_q_q);
    // y[20:7] is representable only when the bits above it are pure sign extension
    top = diff_q[SUM_W-1:OUT_MSB];
    if ((&top) || !(|top)) begin
      sat = diff_q[OUT_MSB:OUT_LSB];
    end else if (diff_q[SUM_W-1]) begin
      sat = {1'b1, {(DAC_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(DAC_W-1){1'b1}}};
    end
    dac_d = en_i ? {~sat[DAC_W-1], sat[DAC_W-2:0]} : DAC_MID;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_i_q  <= '0;
      p_q_q  <= '0;
      diff_q <= '0;
      dac_q  <= DAC_MID;
    end else begin
      p_i_q  <= p_i_d;
      p_q_q  <= p_q_d;
      diff_q <= diff_d;
      dac_q  <= dac_d;
    end
  end

  assign dac_o = dac_q;
endmodule

// File: rtl/dac_chain.sv
// DAC transmit chain: sample-hold interpolation, carrier capture, mixer and DAC control.
module dac_chain
  import dac_chain_pkg::*;
(
  input  logic                 aclk,
  input  logic                 areset,
  dac_chain_if.slave           S_AXIS,
  input  logic [15:0]          S_AXIS_DDS_tdata,
  input  logic                 S_AXIS_DDS_tvalid,
  input  logic [RATIO_W-1:0]   Interp_ratio,
  input  logic [3:0]           DAC_control,
  output logic [DAC_W-1:0]     DAC_data,
  output logic                 DAC_sleep,
  output logic                 PA_enable,
  output logic                 ClockToDAC
);
  logic               en;
  logic               ready;
  logic [RATIO_W-1:0] cnt_q, cnt_d, ratio_q, ratio_d, period;
  iq_t                hold_q, hold_d;
  carrier_t           car_q, car_d;
  logic               sleep_q, pa_q, clkdiv_q;
  logic               unused_inputs;

  assign en            = DAC_control[0];
  assign unused_inputs = ^{S_AXIS.tkeep, S_AXIS.tlast, DAC_control[3:2]};

  always_comb begin
    ready = en && !areset && (cnt_q == '0);
    // Period length is captured on the tready cycle, so ratio edits land at the wrap
    period  = (cnt_q == '0) ? eff_ratio(Interp_ratio) : ratio_q;
    ratio_d = period;
    cnt_d   = '0;
    if (en && (cnt_q != period - RATIO_W'(1))) begin
      cnt_d = cnt_q + RATIO_W'(1);
    end
    hold_d = hold_q;
    if (ready) begin
      hold_d = S_AXIS.tvalid ? iq_t'(S_AXIS.tdata) : '0;
    end
    car_d = S_AXIS_DDS_tvalid ? carrier_t'(S_AXIS_DDS_tdata) : car_q;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q    <= '0;
      ratio_q  <= '0;
      hold_q   <= '0;
      car_q    <= '0;
      sleep_q  <= 1'b1;
      pa_q     <= 1'b0;
      clkdiv_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      hold_q   <= hold_d;
      car_q    <= car_d;
      sleep_q  <= ~en;
      pa_q     <= DAC_control[1] & en;
      clkdiv_q <= ~clkdiv_q;
    end
  end

  dac_chain_mixer u_mixer (
    .clk_i     (aclk),
    .rst_i     (areset),
    .en_i      (en),
    .hold_i    (hold_q),
    .carrier_i (car_q),
    .dac_o     (DAC_data)
  );

  assign S_AXIS.tready = ready;
  assign DAC_sleep     = sleep_q;
  assign PA_enable     = pa_q;
  assign ClockToDAC    = clkdiv_q;
endmodule

// File: tb/tb_dac_chain.sv
// Self-checking bench for dac_chain: vector table, directed corner sequences, randomized run.
module tb_dac_chain;
  import dac_chain_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] dds_tdata;
  logic        dds_tvalid;
  logic [15:0] ratio;
  logic [3:0]  ctl;
  logic [13:0] dac;
  logic        sleep, pa, ckdac;

  dac_chain_if s_axis ();

  always #5 aclk = ~aclk;

  dac_chain dut (
    .aclk              (aclk),
    .areset            (areset),
    .S_AXIS            (s_axis),
    .S_AXIS_DDS_tdata  (dds_tdata),
    .S_AXIS_DDS_tvalid (dds_tvalid),
    .Interp_ratio      (ratio),
    .DAC_control       (ctl),
    .DAC_data          (dac),
    .DAC_sleep         (sleep),
    .PA_enable         (pa),
    .ClockToDAC        (ckdac)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: absolute cycle of the next expected tready, held sample/carrier,
  // and a two-entry queue of mixer results awaiting the output register.
  longint cyc = 0;
  longint next_ready = 0;
  int m_i = 0, m_q = 0, m_cos = 0, m_sin = 0;
  int pipe[$] = '{8192, 8192};
  int m_dac = 8192;
  bit m_sleep = 1'b1, m_pa = 1'b0, m_ck = 1'b0;
  bit obs_ready;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int eff(input logic [15:0] r);
    return (r == 16'd0) ? 1 : int'(r);
  endfunction

  function automatic int mix(input int i, input int q, input int c, input int s);
    int y, r;
    y = i * c - q * s;
    if (y > 1048575)       r = 8191;
    else if (y < -1048576) r = -8192;
    else                   r = y >>> 7;
    return r + 8192;
  endfunction

  task automatic cycle();
    bit exp_rdy;
    int v, old;
    exp_rdy = !areset && ctl[0] && (cyc == next_ready);
    @(negedge aclk);
    obs_ready = s_axis.tready;
    chk("tready", int'(obs_ready), int'(exp_rdy));
    @(posedge aclk);
    #1;
    if (areset) begin
      m_i = 0; m_q = 0; m_cos = 0; m_sin = 0;
      pipe = '{8192, 8192};
      m_dac = 8192; m_sleep = 1'b1; m_pa = 1'b0; m_ck = 1'b0;
      next_ready = cyc + 1;
    end else begin
      v = mix(m_i, m_q, m_cos, m_sin);
      old = pipe.pop_front();
      pipe.push_back(v);
      m_dac = ctl[0] ? old : 8192;
      if (!ctl[0]) next_ready = cyc + 1;
      else if (exp_rdy) next_ready = cyc + eff(ratio);
      if (exp_rdy) begin
        m_i = s_axis.tvalid ? sx16(s_axis.tdata[15:0]) : 0;
        m_q = s_axis.tvalid ? sx16(s_axis.tdata[31:16]) : 0;
      end
      if (dds_tvalid) begin
        m_cos = sx8(dds_tdata[7:0]);
        m_sin = sx8(dds_tdata[15:8]);
      end
      m_sleep = !ctl[0];
      m_pa = ctl[1] & ctl[0];
      m_ck = !m_ck;
    end
    cyc++;
    chk("dac_data", int'(dac), m_dac);
    chk("dac_sleep", int'(sleep), int'(m_sleep));
    chk("pa_enable", int'(pa), int'(m_pa));
    chk("clock_to_dac", int'(ckdac), int'(m_ck));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      n++;
      if (obs_ready) return;
    end
    chk("wait_ready_timeout", 0, 1);
  endtask

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [7:0]  c;
    logic [7:0]  s;
    int          exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, hs;
    logic [15:0] a, b;

    vecs[0] = '{16'h4000, 16'h0000, 8'h7F, 8'h00, 'h3FFF};
    vecs[1] = '{16'h0100, 16'h0100, 8'h40, 8'h40, 'h2000};
    vecs[2] = '{16'h8000, 16'h0000, 8'h7F, 8'h00, 'h0000};
    vecs[3] = '{16'h03E8, 16'h0000, 8'h10, 8'h00, 'h207D};
    vecs[4] = '{16'h0000, 16'h03E8, 8'h00, 8'h10, 'h1F83};
    vecs[5] = '{16'hFFFF, 16'h0000, 8'h01, 8'h00, 'h1FFF};
    vecs[6] = '{16'h7FFF, 16'h0000, 8'h20, 8'h00, 'h3FFF};
    vecs[7] = '{16'h0000, 16'h8000, 8'h00, 8'hE0, 'h0000};
    vecs[8] = '{16'h012C, 16'hFF38, 8'h32, 8'hC4, 'h2017};

    areset = 1'b1; ctl = 4'd0; ratio = 16'd1;
    s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tkeep = '0; s_axis.tlast = 1'b0;
    dds_tdata = '0; dds_tvalid = 1'b0;
    repeat (3) cycle();
    areset = 1'b0;
    cycle();
    chk("rst_tready", int'(s_axis.tready), 0);
    chk("rst_dac", int'(dac), 'h2000);
    chk("rst_sleep", int'(sleep), 1);
    chk("rst_pa", int'(pa), 0);

    // Mixer vectors with R=1: each sample is held steady long enough to reach the output
    ctl = 4'd1; ratio = 16'd1; s_axis.tvalid = 1'b1; dds_tvalid = 1'b1;
    foreach (vecs[k]) begin
      s_axis.tdata = {vecs[k].q, vecs[k].i};
      dds_tdata = {vecs[k].s, vecs[k].c};
      repeat (4) cycle();
      chk("vector", int'(dac), vecs[k].exp);
    end

    // Exact 3-cycle latency from hold load, PA follows control after one cycle
    chk("pa_before", int'(pa), 0);
    ctl = 4'd3; ratio = 16'd10;
    s_axis.tdata = {vecs[0].q, vecs[0].i};
    dds_tdata = {vecs[0].s, vecs[0].c};
    wait_ready(n);
    chk("pa_1cyc", int'(pa), 1);
    chk("sleep_on", int'(sleep), 0);
    cycle(); cycle();
    chk("lat_early", int'(dac), 'h2017);
    cycle();
    chk("lat3", int'(dac), 'h3FFF);

    // R=10 continuous valid: one handshake per ten cycles
    hs = 0;
    for (int k = 0; k < 100; k++) begin
      a = 16'($urandom_range(0, 1023)) - 16'd512;
      b = 16'($urandom_range(0, 1023)) - 16'd512;
      s_axis.tdata = {a, b};
      cycle();
      if (obs_ready && s_axis.tvalid) hs++;
    end
    chk("pulses_r10", hs, 10);

    // Underflow: sample slot with no valid data loads zero
    s_axis.tdata = {vecs[0].q, vecs[0].i};
    wait_ready(n);
    repeat (3) cycle();
    s_axis.tvalid = 1'b0;
    wait_ready(n);
    s_axis.tvalid = 1'b1;
    repeat (3) cycle();
    chk("underflow", int'(dac), 'h2000);

    // Ratio edit mid-period applies at the wrap
    wait_ready(n);
    repeat (3) cycle();
    ratio = 16'd40;
    wait_ready(n);
    chk("period_before_edit", n + 3, 10);
    wait_ready(n);
    chk("period_after_edit", n, 40);
    ratio = 16'd0;
    wait_ready(n);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("ratio0_ready", int'(obs_ready), 1);
    end

    // Disable mid-sample then re-enable
    ratio = 16'd10;
    wait_ready(n);
    repeat (4) cycle();
    ctl = 4'd0;
    repeat (3) cycle();
    chk("disabled_dac", int'(dac), 'h2000);
    ctl = 4'd1;
    cycle();
    chk("reenable_ready", int'(obs_ready), 1);

    // Reset mid-sample
    repeat (4) cycle();
    areset = 1'b1;
    repeat (2) cycle();
    chk("midreset_dac", int'(dac), 'h2000);
    chk("midreset_ck", int'(ckdac), 0);
    areset = 1'b0;

    // Randomized traffic against the model
    ctl = 4'd3;
    for (int k = 0; k < 3000; k++) begin
      s_axis.tvalid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) begin
        s_axis.tdata = $urandom;
      end else begin
        a = 16'($urandom_range(0, 1023)) - 16'd512;
        b = 16'($urandom_range(0, 1023)) - 16'd512;
        s_axis.tdata = {a, b};
      end
      s_axis.tkeep = 4'($urandom);
      s_axis.tlast = 1'($urandom);
      dds_tvalid = ($urandom_range(0, 2) != 0);
      dds_tdata = 16'($urandom);
      if ($urandom_range(0, 49) == 0) ratio = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) ctl = 4'($urandom);
      areset = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
